trace_channel_arbiter: RTL and testbench
========================================

TRACE_CHANNEL_ARBITER -- requirements
Module: trace_channel_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of requesters, legal range 1..16.
REQ-002 SHALL have parameter WIDTH, default 32, meaning the payload bits per beat.
REQ-003 SHALL derive localparam IDX_WIDTH = 1 when N == 1, otherwise $clog2(N).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_valid, input, N bits: per-requester beat valid.
REQ-007 SHALL have port o_ready, output, N bits: per-requester beat accept.
REQ-008 SHALL have port i_data, input, N*WIDTH bits: requester k's data occupies slice [k*WIDTH +: WIDTH].
REQ-009 SHALL have port i_last, input, N bits: per-requester end-of-packet flag.
REQ-010 SHALL have port o_valid, output, 1 bit: shared channel beat valid.
REQ-011 SHALL have port i_ready, input, 1 bit: shared channel sink ready.
REQ-012 SHALL have port o_data, output, WIDTH bits: shared channel data.
REQ-013 SHALL have port o_last, output, 1 bit: shared channel end-of-packet flag.
REQ-014 SHALL have port o_source, output, IDX_WIDTH bits: index of the requester that produced the current output beat.
REQ-015 SHALL have port o_busy, output, 1 bit: high while the FSM is in LOCKED.

Function
REQ-016 SHALL implement a two-state FSM with states IDLE and LOCKED, plus a round-robin pointer ptr (IDX_WIDTH bits) and a registered grant index gnt.
REQ-017 In IDLE with any i_valid bit set, the arbiter SHALL select the first set index scanning ptr, ptr+1, ..., wrapping N-1 -> 0, load gnt with that index, and enter LOCKED on the next edge.
REQ-018 In IDLE, all o_ready bits SHALL be 0; no beat is accepted during the arbitration cycle.
REQ-019 In LOCKED, o_ready[gnt] SHALL equal (!o_valid || i_ready), and every other o_ready bit SHALL be 0.
REQ-020 An input beat SHALL be accepted when i_valid[gnt] && o_ready[gnt]; on acceptance the output register SHALL load o_data, o_last and o_source=gnt, and set o_valid=1 on the next edge.
REQ-021 The output register SHALL clear o_valid when i_ready && o_valid and no new beat is accepted in the same cycle.
REQ-022 Output beat handshake: o_valid, once set, SHALL stay high, and o_data/o_last/o_source SHALL stay stable, until i_ready is sampled high.
REQ-023 Accepting a beat with i_last[gnt]=1 SHALL return the FSM to IDLE and set ptr = (gnt == N-1) ? 0 : gnt+1.
REQ-024 If the granted requester drops i_valid mid-packet, the FSM SHALL stay LOCKED and hold gnt indefinitely; no other requester SHALL be granted.
REQ-025 Requests arriving in the same cycle as a last-beat accept SHALL be arbitrated in the following IDLE cycle using the updated ptr.
REQ-026 Throughput SHALL be one beat per cycle while LOCKED with i_ready held high; latency from i_valid to o_valid SHALL be 2 cycles for the first beat of a packet and 1 cycle for each subsequent beat.
REQ-027 With N == 1, ptr and gnt SHALL stay 0 and the FSM SHALL still pass through IDLE between packets.
REQ-028 o_busy SHALL be 1 exactly when the state is LOCKED.

Reset
REQ-029 When i_rst is high at a clock edge, the block SHALL set state=IDLE, ptr=0, gnt=0, o_valid=0, o_data=0, o_last=0 and o_source=0; o_ready=0 and o_busy=0 then follow from IDLE.
REQ-030 Reset asserted mid-packet SHALL discard any held output beat and the partial packet; after reset the FSM SHALL re-arbitrate from ptr=0.

Verification
REQ-031 The bench SHALL cover a single request: N=4, i_valid=4'b0100, one beat with last=1 and data 0xA5A5A5A5, i_ready=1 -> o_ready[2] high at cycle 1; o_valid=1, o_data=0xA5A5A5A5, o_source=2, o_last=1 at cycle 2; ptr=3 afterwards.
REQ-032 The bench SHALL cover round-robin fairness: all four requesters continuously sending single-beat packets -> o_source sequence 0,1,2,3,0 with an IDLE cycle between packets.
REQ-033 The bench SHALL cover backpressure: a 3-beat packet from requester 1 with i_ready low for 5 cycles after the first beat -> o_data held stable, o_ready[1]=0 while o_valid=1 and i_ready=0, no beat lost or duplicated.
REQ-034 The bench SHALL cover lock hold: requester 0 drops i_valid after beat 1 of 2 while requester 3 is requesting -> o_busy stays 1, o_ready[3] stays 0, and requester 3 is granted only after requester 0's last beat.
REQ-035 The bench SHALL cover reset mid-packet: i_rst pulsed while o_valid=1 -> the next cycle shows o_valid=0, o_busy=0, o_source=0, and the next grant goes to the lowest requesting index.

Source files
------------

// File: rtl/trace_channel_arbiter.sv
// -----------------------------------------------------------------------------
// trace_channel_arbiter
//
// Packet-level round-robin arbiter that merges N trace requesters onto one
// shared valid/ready channel. Once a requester is granted, the channel stays
// locked to it until its last beat has been accepted, so packets never
// interleave on the output.
//
// State table
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | no packet in flight; scan requesters from ptr, load gnt
//   LOCKED | channel owned by requester gnt until its last beat is accepted
//
// Parameters
//   N      number of requesters (1..16)
//   WIDTH  payload bits per beat
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset
//   i_valid   [N]         per-requester beat valid
//   o_ready   [N]         per-requester beat accept
//   i_data    [N*WIDTH]   requester k data at [k*WIDTH +: WIDTH]
//   i_last    [N]         per-requester end-of-packet flag
//   o_valid               shared channel beat valid
//   i_ready               shared channel sink ready
//   o_data    [WIDTH]     shared channel data
//   o_last                shared channel end-of-packet flag
//   o_source  [IDX_WIDTH] requester index of the current output beat
//   o_busy                high while LOCKED
// -----------------------------------------------------------------------------
module trace_channel_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 32,
    localparam int IDX_WIDTH = (N == 1) ? 1 : $clog2(N)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N-1:0]           i_valid,
    output logic [N-1:0]           o_ready,
    input  logic [N*WIDTH-1:0]     i_data,
    input  logic [N-1:0]           i_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_last,
    output logic [IDX_WIDTH-1:0]   o_source,
    output logic                   o_busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N - 1);
    // One extra bit so ptr + offset can exceed N-1 before wrapping.
    localparam logic [IDX_WIDTH:0]   N_EXT    = (IDX_WIDTH + 1)'(N);

    state_t               state_q, state_d;
    logic [IDX_WIDTH-1:0] ptr_q, ptr_d;
    logic [IDX_WIDTH-1:0] gnt_q, gnt_d;

    logic                 req_found;
    logic [IDX_WIDTH-1:0] req_idx;
    logic [IDX_WIDTH:0]   cand;
    logic [IDX_WIDTH-1:0] cand_idx;

    logic                 gnt_valid;
    logic                 gnt_last;
    logic [WIDTH-1:0]     gnt_data;

    logic                 accept;

    // Round-robin scan: first requester with valid set, starting at ptr.
    always_comb begin
        req_found = 1'b0;
        req_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr_q} + (IDX_WIDTH + 1)'(i);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            cand_idx = cand[IDX_WIDTH-1:0];
            if (!req_found && i_valid[cand_idx]) begin
                req_found = 1'b1;
                req_idx   = cand_idx;
            end
        end
    end

    // Mux the granted requester's beat onto internal signals.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        gnt_data  = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt_q == IDX_WIDTH'(k)) begin
                gnt_valid = i_valid[k];
                gnt_last  = i_last[k];
                gnt_data  = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_found) begin
                    gnt_d   = req_idx;
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                // A requester dropping valid mid-packet keeps the lock; only
                // the accepted last beat releases the channel.
                if (accept && gnt_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = (gnt_q == LAST_IDX) ? '0 : gnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        o_ready = '0;
        o_busy  = 1'b0;
        accept  = 1'b0;
        if (state_q == ST_LOCKED) begin
            o_busy = 1'b1;
            // The output register can take a new beat when it is empty or
            // being drained this cycle.
            o_ready[gnt_q] = !o_valid || i_ready;
            accept         = gnt_valid && (!o_valid || i_ready);
        end
    end

    // Output beat register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_last   <= 1'b0;
            o_source <= '0;
        end else if (accept) begin
            o_valid  <= 1'b1;
            o_data   <= gnt_data;
            o_last   <= gnt_last;
            o_source <= gnt_q;
        end else if (o_valid && i_ready) begin
            o_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trace_channel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_trace_channel_arbiter
//
// Bench for trace_channel_arbiter (N=4, WIDTH=32). Requesters are modelled as
// per-index packet sources (beats remaining, current data, hold flag). A
// reference model predicts grants, per-cycle ready/busy/valid and the ordered
// stream of output beats; a separate negedge monitor pops the expected beat
// queue whenever the channel transfers and checks output stability under
// backpressure.
// -----------------------------------------------------------------------------
module tb_trace_channel_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid_v;
    logic [N-1:0]   ready_o;
    logic [N*W-1:0] data_v;
    logic [N-1:0]   last_v;
    logic           ovalid;
    logic           rdy;
    logic [W-1:0]   odata;
    logic           olast;
    logic [1:0]     osrc;
    logic           busy;

    always #5 clk = ~clk;

    trace_channel_arbiter #(.N(N), .WIDTH(W)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (valid_v),
        .o_ready  (ready_o),
        .i_data   (data_v),
        .i_last   (last_v),
        .o_valid  (ovalid),
        .i_ready  (rdy),
        .o_data   (odata),
        .o_last   (olast),
        .o_source (osrc),
        .o_busy   (busy)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         l;
        int           s;
    } beat_t;

    beat_t        exp_q[$];
    int           src_log[$];
    int           n_cmp = 0;
    int           n_err = 0;

    // Requester sources
    int           rem[N];
    logic         hold[N];
    logic         refill[N];
    logic [W-1:0] cur_data[N];

    // Reference model state
    bit           m_locked;
    int           m_gnt;
    int           m_ptr;
    bit           m_ovalid;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            valid_v[r]         = (rem[r] != 0) && !hold[r];
            last_v[r]          = (rem[r] == 1);
            data_v[r*W +: W]   = cur_data[r];
        end
    endtask

    // One clock cycle: drive sources, check per-cycle outputs against the
    // model, advance the model, then move to just after the next rising edge.
    task automatic step();
        logic [N-1:0] er;
        bit           acc;
        int           g;
        int           c;
        drive();
        #5;
        if (rst) begin
            m_locked = 0;
            m_gnt    = 0;
            m_ptr    = 0;
            m_ovalid = 0;
            exp_q.delete();
            for (int r = 0; r < N; r++) begin
                rem[r]    = 0;
                hold[r]   = 1'b0;
                refill[r] = 1'b0;
            end
        end else begin
            er = '0;
            if (m_locked && (!m_ovalid || rdy)) er[m_gnt] = 1'b1;
            chk("o_ready", ready_o, er);
            chk("o_busy", busy, m_locked);
            chk("o_valid", ovalid, m_ovalid);
            acc = m_locked && valid_v[m_gnt] && er[m_gnt];
            if (acc) begin
                g = m_gnt;
                exp_q.push_back('{cur_data[g], (rem[g] == 1), g});
                if (rem[g] == 1) begin
                    m_locked = 0;
                    m_ptr    = (g + 1) % N;
                end
                rem[g]--;
                cur_data[g] = $urandom;
                if (rem[g] == 0 && refill[g]) rem[g] = 1;
            end else if (!m_locked && (valid_v != '0)) begin
                for (int i = N - 1; i >= 0; i--) begin
                    c = (m_ptr + i) % N;
                    if (valid_v[c]) m_gnt = c;
                end
                m_locked = 1;
            end
            m_ovalid = acc ? 1'b1 : (rdy ? 1'b0 : m_ovalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_idle();
        bit done;
        bit quiet;
        done = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            quiet = !m_locked && !m_ovalid && (exp_q.size() == 0);
            for (int r = 0; r < N; r++) if (rem[r] != 0) quiet = 0;
            if (quiet) done = 1;
            else step();
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: channel still busy after 300 cycles at %0t", $time);
        end
    endtask

    // Monitor: scoreboard pop on transfer, stability while stalled.
    beat_t        mon_e;
    bit           have_p = 0;
    logic         pv, pr, pl;
    logic [W-1:0] pd;
    logic [1:0]   ps;

    always @(negedge clk) begin
        if (rst) begin
            have_p = 0;
        end else begin
            if (have_p && pv && !pr) begin
                chk("hold_valid", ovalid, 1);
                chk("hold_data", odata, pd);
                chk("hold_last", olast, pl);
                chk("hold_src", osrc, ps);
            end
            if (ovalid && rdy) begin
                src_log.push_back(int'(osrc));
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h src %0d, expected no beat at %0t", odata, osrc, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", odata, mon_e.d);
                    chk("beat_last", olast, mon_e.l);
                    chk("beat_src", osrc, mon_e.s);
                end
            end
            have_p = 1;
            pv = ovalid;
            pr = rdy;
            pd = odata;
            pl = olast;
            ps = osrc;
        end
    end

    initial begin
        rst = 1'b1;
        rdy = 1'b0;
        for (int r = 0; r < N; r++) begin
            rem[r]      = 0;
            hold[r]     = 1'b0;
            refill[r]   = 1'b0;
            cur_data[r] = $urandom;
        end
        drive();
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_o_valid", ovalid, 0);
        chk("rst_o_busy", busy, 0);
        chk("rst_o_ready", ready_o, 0);
        chk("rst_o_data", odata, 0);
        chk("rst_o_last", olast, 0);
        chk("rst_o_source", osrc, 0);

        // Single request from requester 2
        rdy         = 1'b1;
        cur_data[2] = 32'hA5A5A5A5;
        rem[2]      = 1;
        step();
        chk("single_ready_c1", ready_o, 4'b0100);
        step();
        chk("single_valid_c2", ovalid, 1);
        chk("single_data_c2", odata, 32'hA5A5A5A5);
        chk("single_src_c2", osrc, 2);
        chk("single_last_c2", olast, 1);
        // ptr is now 3: requester 3 must beat requester 0
        rem[0] = 1;
        rem[3] = 1;
        step();
        chk("ptr_wrap_grant", ready_o, 4'b1000);
        run_idle();

        // Round-robin fairness with all requesters always sending
        src_log.delete();
        for (int r = 0; r < N; r++) begin
            rem[r]    = 1;
            refill[r] = 1'b1;
        end
        repeat (20) step();
        for (int r = 0; r < N; r++) refill[r] = 1'b0;
        run_idle();
        chk("rr_count", src_log.size() >= 8, 1);
        for (int i = 1; i < src_log.size(); i++) begin
            chk("rr_order", src_log[i], (src_log[i-1] + 1) % N);
        end

        // Backpressure on a 3-beat packet from requester 1
        rdy    = 1'b1;
        rem[1] = 3;
        step();
        step();
        chk("bp_first_valid", ovalid, 1);
        rdy = 1'b0;
        repeat (5) begin
            step();
            chk("bp_ready1_low", ready_o[1], 0);
        end
        rdy = 1'b1;
        run_idle();

        // Lock hold while requester 3 waits
        rem[0] = 2;
        step();
        rem[3] = 1;
        step();
        hold[0] = 1'b1;
        repeat (4) begin
            step();
            chk("lock_busy", busy, 1);
            chk("lock_ready3", ready_o[3], 0);
        end
        hold[0] = 1'b0;
        run_idle();

        // Reset while a beat is held on the output
        rem[2] = 3;
        step();
        step();
        rdy = 1'b0;
        step();
        chk("pre_rst_valid", ovalid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("post_rst_valid", ovalid, 0);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_src", osrc, 0);
        rdy    = 1'b1;
        rem[1] = 1;
        rem[3] = 1;
        step();
        chk("post_rst_grant", ready_o, 4'b0010);
        run_idle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < N; r++) begin
                if (rem[r] == 0 && $urandom_range(0, 3) == 0) rem[r] = $urandom_range(1, 4);
                hold[r] = ($urandom_range(0, 4) == 0);
            end
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else begin
                step();
            end
        end
        for (int r = 0; r < N; r++) hold[r] = 1'b0;
        rdy = 1'b1;
        run_idle();
        step();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
